// File: rtl/env_rmw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : env_rmw_arbiter
// Purpose  : Round-robin arbiter that serialises per-ant atomic
//            read-modify-write operations (take sugar / deposit signal) onto
//            the single environment lookup/write port.
// Revision : 1.0 - initial release
// ============================================================================
module env_rmw_arbiter #(
    parameter int ANT_NUM     = 8,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 8,
    parameter int SIGNAL_BITS = 4,
    parameter int SIG_DEPOSIT = 3
) (
    input  logic                        newLocClock,
    input  logic                        RESET_SIM,
    input  logic                        PAUSE,
    input  logic [ANT_NUM-1:0]          req,
    input  logic [ANT_NUM*X_BITS-1:0]   req_x,
    input  logic [ANT_NUM*Y_BITS-1:0]   req_y,
    input  logic [ANT_NUM-1:0]          req_take,
    input  logic [ANT_NUM-1:0]          req_deposit,
    output logic [X_BITS-1:0]           lookup_X,
    output logic [Y_BITS-1:0]           lookup_Y,
    input  logic                        lookup_sugar,
    input  logic [SIGNAL_BITS-1:0]      lookup_signal,
    output logic [X_BITS-1:0]           write_X,
    output logic [Y_BITS-1:0]           write_Y,
    output logic                        write_flag,
    output logic                        write_sugar,
    output logic [SIGNAL_BITS-1:0]      write_signal,
    output logic [ANT_NUM-1:0]          grant,
    output logic [ANT_NUM-1:0]          ack,
    output logic                        took_sugar,
    output logic                        busy
);

    localparam int c_idx_w = (ANT_NUM > 1) ? $clog2(ANT_NUM) : 1;
    localparam int c_w1    = c_idx_w + 1;
    localparam int c_sw1   = SIGNAL_BITS + 1;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_lookup = 2'd1;
    localparam logic [1:0] c_modify = 2'd2;
    localparam logic [1:0] c_ack    = 2'd3;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(ANT_NUM - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_w1-1:0]    c_ant_num  = c_w1'(ANT_NUM);
    localparam logic [ANT_NUM-1:0] c_one_ant  = ANT_NUM'(1);
    localparam logic [SIGNAL_BITS:0] c_sig_dep = c_sw1'(SIG_DEPOSIT);
    localparam logic [SIGNAL_BITS:0] c_sig_max = {1'b0, {SIGNAL_BITS{1'b1}}};

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_idx_w-1:0]     r_ptr;
    logic [c_idx_w-1:0]     r_idx;
    logic [X_BITS-1:0]      r_x;
    logic [Y_BITS-1:0]      r_y;
    logic                   r_take;
    logic                   r_dep;
    logic                   r_took;

    logic                   w_found;
    logic [c_idx_w-1:0]     w_win;
    logic [c_w1-1:0]        w_sum;
    logic                   w_start;
    logic [ANT_NUM-1:0]     w_onehot;
    logic                   w_addr_en;
    logic                   w_modify;
    logic [SIGNAL_BITS:0]   w_sig_sum;
    logic [SIGNAL_BITS-1:0] w_sig_new;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < ANT_NUM; i++) begin
            if (!w_found) begin
                w_sum = {1'b0, r_ptr} + c_w1'(i);
                if (w_sum >= c_ant_num) begin
                    w_sum = w_sum - c_ant_num;
                end
                if (req[w_sum[c_idx_w-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_sum[c_idx_w-1:0];
                end
            end
        end
    end

    assign w_start = w_found & ~PAUSE;

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fixed four-phase sequence once a grant is issued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:   if (w_start) w_state_next = c_lookup;
            c_lookup: w_state_next = c_modify;
            c_modify: w_state_next = c_ack;
            c_ack:    w_state_next = c_idle;
            default:  w_state_next = c_idle;
        endcase
    end

    // Transaction context: winner latched at grant so a dropped req still completes.
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_ptr  <= '0;
            r_idx  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_take <= 1'b0;
            r_dep  <= 1'b0;
            r_took <= 1'b0;
        end else begin
            if ((r_state == c_idle) && w_start) begin
                r_idx  <= w_win;
                r_x    <= req_x[w_win*X_BITS +: X_BITS];
                r_y    <= req_y[w_win*Y_BITS +: Y_BITS];
                r_take <= req_take[w_win];
                r_dep  <= req_deposit[w_win];
            end
            if (r_state == c_modify) begin
                r_took <= r_take & lookup_sugar;
            end
            if (r_state == c_ack) begin
                r_ptr <= (r_idx == c_idx_last) ? '0 : (r_idx + c_idx_one);
            end
        end
    end

    // Saturating deposit computed one bit wider so the carry is visible.
    always_comb begin
        w_sig_sum = {1'b0, lookup_signal} + c_sig_dep;
        w_sig_new = lookup_signal;
        if (r_dep) begin
            w_sig_new = (w_sig_sum > c_sig_max) ? {SIGNAL_BITS{1'b1}}
                                                : w_sig_sum[SIGNAL_BITS-1:0];
        end
    end

    assign w_onehot  = c_one_ant << r_idx;
    assign w_addr_en = (r_state == c_lookup) || (r_state == c_modify);
    assign w_modify  = (r_state == c_modify);

    assign busy         = (r_state != c_idle);
    assign grant        = busy ? w_onehot : '0;
    assign ack          = (r_state == c_ack) ? w_onehot : '0;
    assign took_sugar   = (r_state == c_ack) ? r_took : 1'b0;
    assign lookup_X     = w_addr_en ? r_x : '0;
    assign lookup_Y     = w_addr_en ? r_y : '0;
    assign write_X      = w_modify ? r_x : '0;
    assign write_Y      = w_modify ? r_y : '0;
    assign write_flag   = w_modify;
    assign write_sugar  = w_modify & ~r_take & lookup_sugar;
    assign write_signal = w_modify ? w_sig_new : '0;

endmodule
`default_nettype wire
